// File: rtl/adc_sample_averager.sv
// Per-channel block averager for a multiplexed 10-bit ADC stream, with a one-deep result register that uses a valid/ready handshake.
// Optional ADC_AVG_ROUND_EN: round half up and saturate instead of truncating.
module adc_sample_averager #(
   parameter int LOG2_N = 4,
   parameter int NUM_CH = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sample_valid,
   input  logic [9:0] sample_data,
   input  logic [2:0] sample_ch,
   output logic       avg_valid,
   input  logic       avg_ready,
   output logic [9:0] avg_data,
   output logic [2:0] avg_ch,
   output logic       overflow
);

   localparam int DATA_W = 10;
   localparam int ACC_W  = DATA_W + LOG2_N;
   localparam logic [3:0] NUM_CH_L = 4'(NUM_CH);

   typedef logic [ACC_W:0] ext_t;
   localparam ext_t MAX_AVG = ext_t'(2**DATA_W - 1);

   function automatic logic [DATA_W-1:0] scale_avg(input logic [ACC_W-1:0] total);
      ext_t biased;
      ext_t q;
`ifdef ADC_AVG_ROUND_EN
      biased = {1'b0, total} + (ext_t'(1) << (LOG2_N - 1));
`else
      biased = {1'b0, total};
`endif
      q = biased >> LOG2_N;
      if (q > MAX_AVG) return '1;
      return q[DATA_W-1:0];
   endfunction

   logic [ACC_W-1:0]  acc [NUM_CH];
   logic [LOG2_N-1:0] cnt [NUM_CH];

   logic              hit_p0;
   logic              complete_p0;
   logic              accept_p0;
   logic [ACC_W-1:0]  sel_acc_p0;
   logic [LOG2_N-1:0] sel_cnt_p0;
   logic [ACC_W-1:0]  total_p0;

   // Stage p0: select the addressed channel and form its running total
   always_comb begin
      sel_acc_p0 = '0;
      sel_cnt_p0 = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (sample_ch == 3'(i)) begin
            sel_acc_p0 = acc[i];
            sel_cnt_p0 = cnt[i];
         end
      end
   end

   assign hit_p0      = sample_valid && ({1'b0, sample_ch} < NUM_CH_L);
   assign total_p0    = sel_acc_p0 + ACC_W'(sample_data);
   assign complete_p0 = hit_p0 && (sel_cnt_p0 == '1);
   assign accept_p0   = avg_valid && avg_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            acc[i] <= '0;
            cnt[i] <= '0;
         end
      end else if (hit_p0) begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (sample_ch == 3'(i)) begin
               acc[i] <= complete_p0 ? '0 : total_p0;
               cnt[i] <= cnt[i] + LOG2_N'(1);
            end
         end
      end
   end

   // Stage p1: result register; a completion replaces the held result only if the slot is free or being drained
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         avg_valid <= 1'b0;
         avg_data  <= '0;
         avg_ch    <= '0;
         overflow  <= 1'b0;
      end else begin
         if (complete_p0 && (!avg_valid || avg_ready)) begin
            avg_valid <= 1'b1;
            avg_data  <= scale_avg(total_p0);
            avg_ch    <= sample_ch;
         end else if (accept_p0) begin
            avg_valid <= 1'b0;
         end
         if (complete_p0 && avg_valid && !avg_ready)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_adc_sample_averager.sv
// Bench for adc_sample_averager: a per-channel sum/count model checked every cycle, plus directed scenarios with literal expectations.
module tb_adc_sample_averager;

   localparam int LOG2_N = 2;
   localparam int N      = 4;
`ifdef ADC_AVG_ROUND_EN
   localparam int EXP_T1 = 102;
`else
   localparam int EXP_T1 = 101;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       sample_valid = 1'b0;
   logic [9:0] sample_data = '0;
   logic [2:0] sample_ch = '0;
   logic       avg_ready = 1'b1;
   logic       avg_valid;
   logic [9:0] avg_data;
   logic [2:0] avg_ch;
   logic       overflow;

   logic       s4_valid = 1'b0;
   logic [9:0] s4_data = '0;
   logic [2:0] s4_ch = '0;
   logic       r4_ready = 1'b0;
   logic       v4_valid;
   logic [9:0] v4_data;
   logic [2:0] v4_ch;
   logic       o4_ovf;

   adc_sample_averager #(.LOG2_N(LOG2_N), .NUM_CH(8)) dut (
      .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_data(sample_data),
      .sample_ch(sample_ch), .avg_valid(avg_valid), .avg_ready(avg_ready),
      .avg_data(avg_data), .avg_ch(avg_ch), .overflow(overflow));

   adc_sample_averager #(.LOG2_N(LOG2_N), .NUM_CH(4)) dut4 (
      .clk(clk), .rst(rst), .sample_valid(s4_valid), .sample_data(s4_data),
      .sample_ch(s4_ch), .avg_valid(v4_valid), .avg_ready(r4_ready),
      .avg_data(v4_data), .avg_ch(v4_ch), .overflow(o4_ovf));

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int         m_sum [8];
   int         m_cnt [8];
   logic       m_valid;
   int         m_data;
   int         m_ch;
   logic       m_ovf;
   logic       m_fin;
   int         m_res;

   function automatic int avg_of(input int sum);
      int r;
`ifdef ADC_AVG_ROUND_EN
      r = (sum + N / 2) / N;
      if (r > 1023) r = 1023;
`else
      r = sum / N;
`endif
      return r;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            m_sum[i] = 0;
            m_cnt[i] = 0;
         end
         m_valid = 1'b0;
         m_data  = 0;
         m_ch    = 0;
         m_ovf   = 1'b0;
      end else begin
         m_fin = 1'b0;
         m_res = 0;
         if (sample_valid) begin
            m_sum[sample_ch] = m_sum[sample_ch] + int'(sample_data);
            m_cnt[sample_ch] = m_cnt[sample_ch] + 1;
            if (m_cnt[sample_ch] == N) begin
               m_fin = 1'b1;
               m_res = avg_of(m_sum[sample_ch]);
               m_sum[sample_ch] = 0;
               m_cnt[sample_ch] = 0;
            end
         end
         if (m_fin) begin
            if (!m_valid || avg_ready) begin
               m_valid = 1'b1;
               m_data  = m_res;
               m_ch    = int'(sample_ch);
            end else begin
               m_ovf = 1'b1;
            end
         end else if (m_valid && avg_ready) begin
            m_valid = 1'b0;
         end
      end
   end

   always @(posedge clk) begin
      #1;
      check("valid", 32'(avg_valid), 32'(m_valid));
      if (m_valid) begin
         check("data", 32'(avg_data), m_data);
         check("ch", 32'(avg_ch), m_ch);
      end
      check("overflow", 32'(overflow), 32'(m_ovf));
   end

   // Handshakes that will complete on the coming edge
   logic [12:0] got [$];
   always @(negedge clk) begin
      #1;
      if (avg_valid && avg_ready && !rst) got.push_back({avg_ch, avg_data});
   end

   task automatic check_got(input string name, input int idx, input int ch, input int data);
      logic [31:0] act;
      act = (idx < got.size()) ? 32'(got[idx]) : 32'hFFFF_FFFF;
      check(name, act, 32'((ch << 10) | data));
   endtask

   task automatic send(input int ch, input int d);
      @(negedge clk);
      sample_valid = 1'b1;
      sample_ch    = 3'(ch);
      sample_data  = 10'(d);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         sample_valid = 1'b0;
      end
   endtask

   task automatic send4(input int ch, input int d);
      @(negedge clk);
      s4_valid = 1'b1;
      s4_ch    = 3'(ch);
      s4_data  = 10'(d);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1'b1;
      sample_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      check("rst_valid", 32'(avg_valid), 0);
      check("rst_data", 32'(avg_data), 0);
      check("rst_ch", 32'(avg_ch), 0);
      check("rst_ovf", 32'(overflow), 0);
      rst = 1'b0;

      // single channel average, latency 1
      avg_ready = 1'b1;
      for (int i = 0; i < 4; i++) send(3, 100 + i);
      idle(1);
      check("t1_valid", 32'(avg_valid), 1);
      check("t1_data", 32'(avg_data), EXP_T1);
      check("t1_ch", 32'(avg_ch), 3);
      idle(1);
      check("t1_drop", 32'(avg_valid), 0);

      // interleaved extremes
      got.delete();
      for (int i = 0; i < 4; i++) begin
         send(0, 1023);
         send(7, 0);
      end
      idle(3);
      check("t2_count", got.size(), 2);
      check_got("t2_first", 0, 0, 1023);
      check_got("t2_second", 1, 7, 0);

      // held result, second completion dropped
      got.delete();
      avg_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(1, 10);
      for (int i = 0; i < 4; i++) send(2, 20);
      idle(1);
      check("t3_valid", 32'(avg_valid), 1);
      check("t3_data", 32'(avg_data), 10);
      check("t3_ch", 32'(avg_ch), 1);
      check("t3_ovf", 32'(overflow), 1);
      avg_ready = 1'b1;
      @(negedge clk);
      avg_ready = 1'b0;
      check("t3_drop", 32'(avg_valid), 0);
      check("t3_count", got.size(), 1);
      check_got("t3_first", 0, 1, 10);

      pulse_rst();
      check("t3_rst_ovf", 32'(overflow), 0);

      // completion on the same edge as a handshake
      got.delete();
      avg_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(4, 8);
      for (int i = 0; i < 3; i++) send(5, 16);
      send(5, 16);
      avg_ready = 1'b1;
      idle(1);
      check("t4_valid", 32'(avg_valid), 1);
      check("t4_data", 32'(avg_data), 16);
      check("t4_ch", 32'(avg_ch), 5);
      check("t4_ovf", 32'(overflow), 0);
      idle(1);
      check("t4_drop", 32'(avg_valid), 0);
      check("t4_count", got.size(), 2);
      check_got("t4_first", 0, 4, 8);
      check_got("t4_second", 1, 5, 16);

      // reset mid-accumulation, sample presented during reset is ignored
      got.delete();
      for (int i = 0; i < 3; i++) send(5, 99);
      @(negedge clk);
      rst = 1'b1;
      sample_valid = 1'b1;
      sample_ch = 3'd5;
      sample_data = 10'd500;
      @(negedge clk);
      rst = 1'b0;
      sample_valid = 1'b0;
      for (int i = 0; i < 3; i++) send(5, 40);
      idle(1);
      check("t5_early", got.size(), 0);
      send(5, 40);
      idle(2);
      check("t5_count", got.size(), 1);
      check_got("t5_result", 0, 5, 40);
      check("t5_ovf", 32'(overflow), 0);

      // out-of-range channel on the 4-channel instance
      r4_ready = 1'b0;
      send4(2, 4);
      send4(2, 4);
      for (int i = 0; i < 4; i++) send4(6, 1000);
      @(negedge clk);
      s4_valid = 1'b0;
      check("t6_none", 32'(v4_valid), 0);
      send4(2, 4);
      check("t6_before_last", 32'(v4_valid), 0);
      send4(2, 4);
      @(negedge clk);
      s4_valid = 1'b0;
      check("t6_valid", 32'(v4_valid), 1);
      check("t6_data", 32'(v4_data), 4);
      check("t6_ch", 32'(v4_ch), 2);
      check("t6_ovf", 32'(o4_ovf), 0);

      idle(2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/adc_sample_averager.md
ADC_SAMPLE_AVERAGER -- requirements
Module: adc_sample_averager

Interface
REQ-001 SHALL have parameter LOG2_N, default 4, meaning log2 of samples averaged per result (legal 1..6).
REQ-002 SHALL have parameter NUM_CH, default 8, meaning number of ADC channels tracked (legal 1..8).
REQ-003 SHALL have port clk  input  1  single clock; all state on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port sample_valid  input  1  one-cycle strobe; a new converted sample is present.
REQ-006 SHALL have port sample_data  input  10  unsigned MCP3008 conversion result.
REQ-007 SHALL have port sample_ch  input  3  channel the sample was taken on.
REQ-008 SHALL have port avg_valid  output  1  averaged result held on avg_data/avg_ch.
REQ-009 SHALL have port avg_ready  input  1  consumer accepts the result when high with avg_valid.
REQ-010 SHALL have port avg_data  output  10  averaged sample.
REQ-011 SHALL have port avg_ch  output  3  channel of avg_data.
REQ-012 SHALL have port overflow  output  1  sticky; a completed average was dropped.

Function
REQ-013 SHALL keep per channel an accumulator of 10+LOG2_N bits and a sample counter of LOG2_N bits; no accumulator overflow is possible.
REQ-014 SHALL, on sample_valid with sample_ch < NUM_CH, add sample_data to acc[sample_ch] and increment cnt[sample_ch] in the same edge.
REQ-015 SHALL ignore sample_valid with sample_ch >= NUM_CH (no state change).
REQ-016 SHALL treat the sample that makes cnt wrap from 2^LOG2_N-1 to 0 as completing: total = acc + sample_data; acc cleared to 0 on that edge.
REQ-017 SHALL, on completion, load avg_data = total >> LOG2_N (see Configuration), avg_ch = sample_ch, and assert avg_valid on the following cycle (latency 1 clk from the completing sample).
REQ-018 SHALL hold avg_valid, avg_data, avg_ch stable until a cycle where avg_valid and avg_ready are both high; avg_valid then drops next cycle unless REQ-019 applies.
REQ-019 SHALL, when completion coincides with an accepting handshake, load the new result and keep avg_valid high (back-to-back, no bubble).
REQ-020 SHALL, when completion occurs while avg_valid is high and avg_ready is low, drop the new result, keep the held result unchanged, and set overflow; the channel's acc/cnt still clear.
REQ-021 SHALL keep overflow set until reset.
REQ-022 SHALL keep channels independent; interleaved samples of different channels never mix sums.
REQ-023 SHALL accept a sample every cycle (no backpressure on the input side).

Reset
REQ-024 SHALL, on rst high, asynchronously clear all accumulators, counters, avg_valid, avg_data, avg_ch and overflow to 0.
REQ-025 SHALL discard partial sums and any undelivered result when rst asserts mid-operation; first post-reset average needs 2^LOG2_N fresh samples.
REQ-026 SHALL ignore sample_valid while rst is high.

Configuration
REQ-027 SHALL, with ADC_AVG_ROUND_EN defined, compute avg_data = min(1023, (total + 2^(LOG2_N-1)) >> LOG2_N) (round half up, saturated).
REQ-028 SHALL, without ADC_AVG_ROUND_EN, compute avg_data = total >> LOG2_N (truncation); no other behaviour differs.

Verification (LOG2_N=2, NUM_CH=8 unless noted)
REQ-029 SHALL cover: ch3 samples 100,101,102,103, avg_ready=1 -> one avg_valid pulse, avg_ch=3, avg_data=101 without macro, 102 with macro, latency 1 clk after 4th sample.
REQ-030 SHALL cover: interleaved ch0=1023 x4 and ch7=0 x4 alternating each cycle -> results ch0=1023 (also with macro, saturation) and ch7=0, in completion order.
REQ-031 SHALL cover: avg_ready=0, ch1 completes (avg 10) then ch2 completes (avg 20) -> avg_data stays 10, avg_ch=1, overflow=1; raise avg_ready -> one handshake, avg_valid low next cycle.
REQ-032 SHALL cover: completion on same cycle as handshake of a held result -> avg_valid stays high, new data presented next cycle, overflow stays 0.
REQ-033 SHALL cover: 3 samples on ch5, assert rst for 1 cycle, then 4 samples of 40 -> single result 40, no earlier output, overflow 0.
REQ-034 SHALL cover: sample_valid with sample_ch=6 at NUM_CH=4 -> no counter change, no output.
